// File: rtl/interpolation_control_pkg.sv
// Shared types and constants for the interpolation control slice.
// Also used by the upstream fetcher for burst sizing.
package interpolation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H_LOAD,
        ST_H_FILT,
        ST_H_RUN,
        ST_V_FILT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_FULL,
        MODE_Y_ONLY,
        MODE_X_ONLY,
        MODE_COPY
    } mode_t;

    localparam int unsigned LINES_FULL  = 9;
    localparam int unsigned LINES_SHORT = 4;
    localparam int unsigned COUNT_END_V = 13;

    function automatic logic uses_vertical(mode_t mode);
        return (mode == MODE_FULL) || (mode == MODE_Y_ONLY);
    endfunction

    function automatic logic [3:0] lines_for_mode(mode_t mode);
        return uses_vertical(mode) ? 4'(LINES_FULL) : 4'(LINES_SHORT);
    endfunction

endpackage

// File: rtl/interpolation_control_if.sv
// Job, fetcher and datapath-control signals of the interpolation controller.
// master = controller side, slave = fetcher/datapath/environment side.
interface interpolation_control_if;
    logic       START;
    logic [3:0] FRAC_MV_X;
    logic [3:0] FRAC_MV_Y;
    logic       LINE_VALID;
    logic       LOOP_4;
    logic       LOOP_9;
    logic       LOOP_13;
    logic       BUSY;
    logic       DONE;
    logic       LINE_REQ;
    logic       OUT_VALID;
    logic       RST_ASYNC_INTERP;
    logic       RST_ASYNC_REG_COUNTER;
    logic       WRITE_REG_INPUT_LINE;
    logic       WRITE_REG_COUNTER;
    logic       WRITE_REG_INT_OUT;
    logic       WRITE_BUFFER;
    logic       SEL_BUFFER_IN;
    logic       SEL_INTERP_IN;
    logic       SEL_DIMENSION;

    modport master (
        input  START, FRAC_MV_X, FRAC_MV_Y, LINE_VALID, LOOP_4, LOOP_9, LOOP_13,
        output BUSY, DONE, LINE_REQ, OUT_VALID, RST_ASYNC_INTERP, RST_ASYNC_REG_COUNTER,
               WRITE_REG_INPUT_LINE, WRITE_REG_COUNTER, WRITE_REG_INT_OUT, WRITE_BUFFER,
               SEL_BUFFER_IN, SEL_INTERP_IN, SEL_DIMENSION
    );

    modport slave (
        output START, FRAC_MV_X, FRAC_MV_Y, LINE_VALID, LOOP_4, LOOP_9, LOOP_13,
        input  BUSY, DONE, LINE_REQ, OUT_VALID, RST_ASYNC_INTERP, RST_ASYNC_REG_COUNTER,
               WRITE_REG_INPUT_LINE, WRITE_REG_COUNTER, WRITE_REG_INT_OUT, WRITE_BUFFER,
               SEL_BUFFER_IN, SEL_INTERP_IN, SEL_DIMENSION
    );
endinterface

// File: rtl/interp_mode_decode.sv
// Classifies a fractional motion vector into one of the four interpolation modes.
module interp_mode_decode
    import interpolation_pkg::*;
(
    input  logic [3:0] FRAC_MV_X,
    input  logic [3:0] FRAC_MV_Y,
    output mode_t      MODE
);
    always_comb begin
        case ({FRAC_MV_X != '0, FRAC_MV_Y != '0})
            2'b11:   MODE = MODE_FULL;
            2'b01:   MODE = MODE_Y_ONLY;
            2'b10:   MODE = MODE_X_ONLY;
            default: MODE = MODE_COPY;
        endcase
    end
endmodule

// File: rtl/interpolation_control.sv
// Control FSM for the 4x4 fractional-sample interpolation datapath.
// Define INTERP_PIPELINE_EN to overlap line loading with horizontal filtering (H_RUN).
module interpolation_control
    import interpolation_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST_ASYNC_N,
    interpolation_control_if.master bus
);
`ifdef INTERP_PIPELINE_EN
    localparam state_t H_ENTRY = ST_H_RUN;
`else
    localparam state_t H_ENTRY = ST_H_LOAD;
`endif

    state_t     state_q, state_d;
    mode_t      mode_dec, mode_q;
    logic [3:0] pass_cnt_q;
    logic       use_v, x_int, last_h_row, last_v_col;
    logic       cnt_run_q, out_valid_q;
    logic       wr_line, wr_cnt, wr_int, wr_buf;
    logic       sel_buf, sel_interp, sel_dim, line_req, done;

    interp_mode_decode u_mode_decode (
        .FRAC_MV_X (bus.FRAC_MV_X),
        .FRAC_MV_Y (bus.FRAC_MV_Y),
        .MODE      (mode_dec)
    );

    assign use_v = uses_vertical(mode_q);
    assign x_int = (mode_q == MODE_Y_ONLY) || (mode_q == MODE_COPY);

    // pass_cnt_q shadows the datapath counter so a pass ends on the cycle whose
    // increment reaches the LOOP_* value; a flag already low ends it as well.
    assign last_h_row = (pass_cnt_q == lines_for_mode(mode_q) - 4'd1)
                      || (use_v ? !bus.LOOP_9 : !bus.LOOP_4);
    assign last_v_col = (pass_cnt_q == 4'(COUNT_END_V - 1)) || !bus.LOOP_13;

`ifdef INTERP_PIPELINE_EN
    logic [3:0] lines_q;
    logic       row_pend_q;

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            lines_q    <= '0;
            row_pend_q <= 1'b0;
        end else begin
            lines_q    <= (state_q == ST_IDLE) ? '0 : lines_q + {3'd0, wr_line};
            row_pend_q <= (state_q == ST_H_RUN) && wr_line;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_COPY;
            pass_cnt_q  <= '0;
            cnt_run_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.START)
                mode_q <= mode_dec;
            if (state_q == ST_IDLE)
                pass_cnt_q <= '0;
            else if (wr_cnt)
                pass_cnt_q <= pass_cnt_q + 4'd1;
            cnt_run_q   <= (state_d != ST_IDLE);
            out_valid_q <= wr_int;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_line    = 1'b0;
        wr_cnt     = 1'b0;
        wr_int     = 1'b0;
        wr_buf     = 1'b0;
        sel_buf    = 1'b0;
        sel_interp = 1'b0;
        sel_dim    = 1'b0;
        line_req   = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START)
                    state_d = H_ENTRY;
            end
`ifdef INTERP_PIPELINE_EN
            ST_H_RUN: begin
                line_req   = (lines_q != lines_for_mode(mode_q));
                wr_line    = line_req && bus.LINE_VALID;
                sel_interp = 1'b1;
                sel_dim    = 1'b1;
                sel_buf    = x_int;
                wr_cnt     = row_pend_q;
                wr_buf     = row_pend_q && use_v;
                wr_int     = row_pend_q && !use_v;
                if (row_pend_q && last_h_row)
                    state_d = use_v ? ST_V_FILT : ST_DONE;
            end
`else
            ST_H_LOAD: begin
                line_req   = 1'b1;
                sel_interp = 1'b1;
                wr_line    = bus.LINE_VALID;
                if (bus.LINE_VALID)
                    state_d = ST_H_FILT;
            end
            ST_H_FILT: begin
                sel_interp = 1'b1;
                sel_dim    = 1'b1;
                sel_buf    = x_int;
                wr_cnt     = 1'b1;
                wr_buf     = use_v;
                wr_int     = !use_v;
                if (!last_h_row)
                    state_d = ST_H_LOAD;
                else
                    state_d = use_v ? ST_V_FILT : ST_DONE;
            end
`endif
            ST_V_FILT: begin
                wr_int = 1'b1;
                wr_cnt = 1'b1;
                if (last_v_col)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.BUSY                  = (state_q != ST_IDLE);
    assign bus.DONE                  = done;
    assign bus.LINE_REQ              = line_req;
    assign bus.OUT_VALID             = out_valid_q;
    assign bus.RST_ASYNC_INTERP      = RST_ASYNC_N;
    assign bus.RST_ASYNC_REG_COUNTER = cnt_run_q;
    assign bus.WRITE_REG_INPUT_LINE  = wr_line;
    assign bus.WRITE_REG_COUNTER     = wr_cnt;
    assign bus.WRITE_REG_INT_OUT     = wr_int;
    assign bus.WRITE_BUFFER          = wr_buf;
    assign bus.SEL_BUFFER_IN         = sel_buf;
    assign bus.SEL_INTERP_IN         = sel_interp;
    assign bus.SEL_DIMENSION         = sel_dim;
endmodule

// File: tb/tb_interpolation_control.sv
// Directed self-checking bench for interpolation_control, with a behavioural datapath counter
// driving the LOOP_* flags. Expectations follow INTERP_PIPELINE_EN when it is defined.
module tb_interpolation_control;
`ifdef INTERP_PIPELINE_EN
    localparam int LAT_LONG = 16, LAT_SHORT = 7, LAT_STALL = 19, WB_RUN = 9, STALL_EN = 1;
`else
    localparam int LAT_LONG = 24, LAT_SHORT = 10, LAT_STALL = 27, WB_RUN = 1, STALL_EN = 0;
`endif

    typedef struct {
        int lat; int lines; int wbuf; int selbuf; int iout; int iout_dim; int ov; int ov_bad;
        int cnt; int stall_en; int max_run; int rst_bad; int extra_done; int busy_after;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] dp_cnt = '0;
    int total = 0;
    int bad = 0;

    interpolation_control_if ifc ();

    interpolation_control dut (
        .CLK         (clk),
        .RST_ASYNC_N (rst_n),
        .bus         (ifc)
    );

    always #5 clk = ~clk;

    // Datapath loop counter: cleared while RST_ASYNC_REG_COUNTER is low, counts on WRITE_REG_COUNTER.
    always @(posedge clk or negedge ifc.RST_ASYNC_REG_COUNTER) begin
        if (!ifc.RST_ASYNC_REG_COUNTER) dp_cnt <= '0;
        else if (ifc.WRITE_REG_COUNTER) dp_cnt <= dp_cnt + 4'd1;
    end
    assign ifc.LOOP_4  = (dp_cnt != 4'd4);
    assign ifc.LOOP_9  = (dp_cnt != 4'd9);
    assign ifc.LOOP_13 = (dp_cnt != 4'd13);

    function automatic logic [11:0] outs();
        return {ifc.BUSY, ifc.DONE, ifc.LINE_REQ, ifc.OUT_VALID, ifc.RST_ASYNC_REG_COUNTER,
                ifc.WRITE_REG_INPUT_LINE, ifc.WRITE_REG_COUNTER, ifc.WRITE_REG_INT_OUT,
                ifc.WRITE_BUFFER, ifc.SEL_BUFFER_IN, ifc.SEL_INTERP_IN, ifc.SEL_DIMENSION};
    endfunction

    // Runs one job from START to DONE (cycle of START = 1) and gathers observations.
    task automatic run_job(input logic [3:0] x, input logic [3:0] y, input int stall_line,
                           input int stall_len, input int restart_at, output obs_t o);
        int stall_left;
        int run;
        logic prev_int;
        logic stalled;
        logic seen;
        o = '{default: 0};
        stall_left = stall_len;
        run = 0;
        prev_int = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        ifc.FRAC_MV_X = x; ifc.FRAC_MV_Y = y; ifc.START = 1'b1; ifc.LINE_VALID = 1'b1;
        o.lat = 1;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk); #1;
            o.lat++;
            ifc.START = (o.lat == restart_at);
            ifc.FRAC_MV_X = (o.lat == restart_at) ? 4'd0 : x;
            ifc.FRAC_MV_Y = (o.lat == restart_at) ? 4'd0 : y;
            stalled = (stall_left > 0) && (o.lines == stall_line - 1) && ifc.LINE_REQ;
            if (stalled) stall_left--;
            ifc.LINE_VALID = !stalled;
            #1;
            if (ifc.WRITE_REG_INPUT_LINE) o.lines++;
            if (ifc.WRITE_BUFFER) begin
                o.wbuf++;
                run++;
                if (run > o.max_run) o.max_run = run;
                if (ifc.SEL_BUFFER_IN) o.selbuf++;
            end else begin
                run = 0;
            end
            if (ifc.WRITE_REG_INT_OUT) o.iout++;
            if (ifc.WRITE_REG_INT_OUT && ifc.SEL_DIMENSION) o.iout_dim++;
            if (ifc.OUT_VALID) o.ov++;
            if (ifc.OUT_VALID !== prev_int) o.ov_bad++;
            prev_int = ifc.WRITE_REG_INT_OUT;
            if (ifc.WRITE_REG_COUNTER) o.cnt++;
            if (ifc.BUSY && !ifc.RST_ASYNC_REG_COUNTER) o.rst_bad++;
            if (stalled && (ifc.WRITE_REG_INPUT_LINE || ifc.WRITE_REG_COUNTER ||
                            ifc.WRITE_REG_INT_OUT || ifc.WRITE_BUFFER)) o.stall_en++;
            seen = ifc.DONE;
        end
        if (!seen) o.lat = -1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            ifc.START = 1'b0;
            #1;
            if (ifc.DONE) o.extra_done++;
            if (ifc.OUT_VALID) o.ov++;
            if (ifc.OUT_VALID !== prev_int) o.ov_bad++;
            prev_int = ifc.WRITE_REG_INT_OUT;
        end
        o.busy_after = ifc.BUSY ? 1 : 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.START = 1'b0; ifc.FRAC_MV_X = 4'd0; ifc.FRAC_MV_Y = 4'd0; ifc.LINE_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (outs() !== 12'd0) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 12'd0); end
        total++; if (ifc.RST_ASYNC_INTERP !== 1'b0) begin bad++; $display("FAIL reset_interp_low got=%b exp=0", ifc.RST_ASYNC_INTERP); end
        rst_n = 1'b1;
        #1;
        total++; if (ifc.RST_ASYNC_INTERP !== 1'b1) begin bad++; $display("FAIL reset_interp_high got=%b exp=1", ifc.RST_ASYNC_INTERP); end
        ifc.LINE_VALID = 1'b1;
        @(posedge clk); #2;
        total++; if (outs() !== 12'd0) begin bad++; $display("FAIL idle_outs got=%b exp=%b", outs(), 12'd0); end
    endtask

    task automatic test_full();
        obs_t o;
        run_job(4'd5, 4'd3, 0, 0, 0, o);
        total++; if (o.lat !== LAT_LONG) begin bad++; $display("FAIL full_latency got=%0d exp=%0d", o.lat, LAT_LONG); end
        total++; if (o.lines !== 9) begin bad++; $display("FAIL full_lines got=%0d exp=9", o.lines); end
        total++; if (o.wbuf !== 9) begin bad++; $display("FAIL full_write_buffer got=%0d exp=9", o.wbuf); end
        total++; if (o.selbuf !== 0) begin bad++; $display("FAIL full_sel_buffer got=%0d exp=0", o.selbuf); end
        total++; if (o.iout !== 4) begin bad++; $display("FAIL full_int_out got=%0d exp=4", o.iout); end
        total++; if (o.iout_dim !== 0) begin bad++; $display("FAIL full_v_sel_dim got=%0d exp=0", o.iout_dim); end
        total++; if (o.ov !== 4) begin bad++; $display("FAIL full_out_valid got=%0d exp=4", o.ov); end
        total++; if (o.ov_bad !== 0) begin bad++; $display("FAIL full_out_valid_align got=%0d exp=0", o.ov_bad); end
        total++; if (o.cnt !== 13) begin bad++; $display("FAIL full_counter_writes got=%0d exp=13", o.cnt); end
        total++; if (o.max_run !== WB_RUN) begin bad++; $display("FAIL full_wbuf_run got=%0d exp=%0d", o.max_run, WB_RUN); end
        total++; if (o.rst_bad !== 0) begin bad++; $display("FAIL full_cnt_rst_busy got=%0d exp=0", o.rst_bad); end
        total++; if (o.extra_done !== 0) begin bad++; $display("FAIL full_extra_done got=%0d exp=0", o.extra_done); end
        total++; if (o.busy_after !== 0) begin bad++; $display("FAIL full_busy_after got=%0d exp=0", o.busy_after); end
    endtask

    task automatic test_y_only();
        obs_t o;
        run_job(4'd0, 4'd8, 0, 0, 0, o);
        total++; if (o.lat !== LAT_LONG) begin bad++; $display("FAIL yonly_latency got=%0d exp=%0d", o.lat, LAT_LONG); end
        total++; if (o.wbuf !== 9) begin bad++; $display("FAIL yonly_write_buffer got=%0d exp=9", o.wbuf); end
        total++; if (o.selbuf !== 9) begin bad++; $display("FAIL yonly_sel_buffer got=%0d exp=9", o.selbuf); end
        total++; if (o.iout_dim !== 0) begin bad++; $display("FAIL yonly_v_sel_dim got=%0d exp=0", o.iout_dim); end
        total++; if (o.ov !== 4) begin bad++; $display("FAIL yonly_out_valid got=%0d exp=4", o.ov); end
    endtask

    task automatic test_x_only_copy();
        logic [3:0] xs [2];
        obs_t o;
        xs[0] = 4'd7;
        xs[1] = 4'd0;
        for (int i = 0; i < 2; i++) begin
            run_job(xs[i], 4'd0, 0, 0, 0, o);
            total++; if (o.lat !== LAT_SHORT) begin bad++; $display("FAIL short%0d_latency got=%0d exp=%0d", i, o.lat, LAT_SHORT); end
            total++; if (o.lines !== 4) begin bad++; $display("FAIL short%0d_lines got=%0d exp=4", i, o.lines); end
            total++; if (o.wbuf !== 0) begin bad++; $display("FAIL short%0d_write_buffer got=%0d exp=0", i, o.wbuf); end
            total++; if (o.ov !== 4) begin bad++; $display("FAIL short%0d_out_valid got=%0d exp=4", i, o.ov); end
            total++; if (o.iout_dim !== 4) begin bad++; $display("FAIL short%0d_h_sel_dim got=%0d exp=4", i, o.iout_dim); end
            total++; if (o.cnt !== 4) begin bad++; $display("FAIL short%0d_counter_writes got=%0d exp=4", i, o.cnt); end
            total++; if (o.selbuf !== 0) begin bad++; $display("FAIL short%0d_sel_buffer got=%0d exp=0", i, o.selbuf); end
        end
    endtask

    task automatic test_stall();
        obs_t o;
        run_job(4'd5, 4'd3, 5, 3, 0, o);
        total++; if (o.lat !== LAT_STALL) begin bad++; $display("FAIL stall_latency got=%0d exp=%0d", o.lat, LAT_STALL); end
        total++; if (o.stall_en !== STALL_EN) begin bad++; $display("FAIL stall_enables got=%0d exp=%0d", o.stall_en, STALL_EN); end
        total++; if (o.lines !== 9) begin bad++; $display("FAIL stall_lines got=%0d exp=9", o.lines); end
        total++; if (o.wbuf !== 9) begin bad++; $display("FAIL stall_write_buffer got=%0d exp=9", o.wbuf); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_job(4'd5, 4'd3, 0, 0, 5, o);
        total++; if (o.lat !== LAT_LONG) begin bad++; $display("FAIL restart_latency got=%0d exp=%0d", o.lat, LAT_LONG); end
        total++; if (o.wbuf !== 9) begin bad++; $display("FAIL restart_write_buffer got=%0d exp=9", o.wbuf); end
        total++; if (o.extra_done !== 0) begin bad++; $display("FAIL restart_second_done got=%0d exp=0", o.extra_done); end
        total++; if (o.busy_after !== 0) begin bad++; $display("FAIL restart_busy_after got=%0d exp=0", o.busy_after); end
    endtask

    task automatic test_reset_mid_job();
        int lat;
        int dones;
        int busy;
        @(posedge clk); #1;
        ifc.FRAC_MV_X = 4'd5; ifc.FRAC_MV_Y = 4'd3; ifc.START = 1'b1; ifc.LINE_VALID = 1'b1;
        lat = 1;
        while (lat < LAT_LONG - 2) begin
            @(posedge clk); #1;
            lat++;
            ifc.START = 1'b0;
        end
        #1;
        total++; if (ifc.WRITE_REG_INT_OUT !== 1'b1 || ifc.SEL_DIMENSION !== 1'b0) begin
            bad++; $display("FAIL rst_in_vfilt got=%b%b exp=10", ifc.WRITE_REG_INT_OUT, ifc.SEL_DIMENSION); end
        rst_n = 1'b0;
        #1;
        total++; if (outs() !== 12'd0) begin bad++; $display("FAIL rst_mid_outs got=%b exp=%b", outs(), 12'd0); end
        total++; if (ifc.RST_ASYNC_INTERP !== 1'b0) begin bad++; $display("FAIL rst_mid_interp got=%b exp=0", ifc.RST_ASYNC_INTERP); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ifc.DONE) dones++;
            if (ifc.BUSY) busy++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL rst_mid_done got=%0d exp=0", dones); end
        total++; if (busy !== 0) begin bad++; $display("FAIL rst_mid_busy got=%0d exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_full();
        test_y_only();
        test_x_only_copy();
        test_stall();
        test_back_to_back();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/interpolation_control.md
# interpolation_control

Control FSM for the 4×4 fractional-sample interpolation datapath. Accepts one block job (fractional MV) per START and picks one of four modes from the fractional parts. Requests integer sample lines from the upstream fetcher. Drives every write enable, select and counter reset of the datapath, using the datapath's LOOP_* flags to end each pass, and flags each valid output row to downstream.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  clock
- RST_ASYNC_N  in  1  asynchronous active-low reset
- START  in  1  job request; sampled in IDLE only
- FRAC_MV_X, FRAC_MV_Y  in  4 each  fractional MV; latched on accepted START
- LINE_VALID  in  1  upstream integer line present on datapath INTEGER_SAMPLES
- LOOP_4, LOOP_9, LOOP_13  in  1 each  datapath flags; low when counter equals 4/9/13
- BUSY  out  1  job in progress
- DONE  out  1  one-cycle pulse, job finished
- LINE_REQ  out  1  requesting next integer line
- OUT_VALID  out  1  datapath INTERP_OUT_0..3 hold a new row
- RST_ASYNC_INTERP  out  1  equals RST_ASYNC_N (combinational pass-through)
- RST_ASYNC_REG_COUNTER  out  1  registered, active-low counter clear
- WRITE_REG_INPUT_LINE, WRITE_REG_COUNTER, WRITE_REG_INT_OUT, WRITE_BUFFER  out  1 each
- SEL_BUFFER_IN, SEL_INTERP_IN, SEL_DIMENSION  out  1 each

## Operation
- Modes, latched at START:
  - FULL: X≠0, Y≠0.
  - Y_ONLY: X=0, Y≠0.
  - X_ONLY: X≠0, Y=0.
  - COPY: both 0.
- States:
  - IDLE: RST_ASYNC_REG_COUNTER=0 (counter held at 0). START=1 → latch mode → H_LOAD.
  - H_LOAD: LINE_REQ=1, SEL_INTERP_IN=1. WRITE_REG_INPUT_LINE=LINE_VALID; on LINE_VALID → H_FILT, else stall.
  - H_FILT: SEL_INTERP_IN=1, SEL_DIMENSION=1, WRITE_REG_COUNTER=1. SEL_BUFFER_IN=1 in Y_ONLY/COPY, else 0.
    - FULL/Y_ONLY: WRITE_BUFFER=1. Next state V_FILT when counter will reach 9 (LOOP_9 already low next cycle), else H_LOAD.
    - X_ONLY/COPY: WRITE_REG_INT_OUT=1. Next state DONE_ST after the 4th row, else H_LOAD.
  - V_FILT: SEL_INTERP_IN=0, SEL_DIMENSION=0, SEL_BUFFER_IN=0, WRITE_REG_INT_OUT=1, WRITE_REG_COUNTER=1. Counter 9..12 selects buffer columns 0..3. Exit to DONE_ST when LOOP_13 low.
  - DONE_ST: DONE=1 for one cycle → IDLE.
- Line counts: FULL/Y_ONLY consume 9 lines; X_ONLY/COPY consume 4. The upstream fetcher sizes its burst from the same MV.
- BUSY=1 in every state except IDLE.
- START while BUSY: ignored, no queuing.
- LINE_VALID outside H_LOAD: ignored.
- FRAC inputs may change after START without effect on mode. The datapath still reads FRAC_MV_X/Y live, so upstream holds them stable until DONE.

## Timing
- Reset: state IDLE; all outputs 0 except RST_ASYNC_INTERP, which follows RST_ASYNC_N.
- Async reset mid-job: immediate return to IDLE; the partial job is discarded with no DONE.
- OUT_VALID is WRITE_REG_INT_OUT delayed one cycle, aligned to the register update.
- Latency from START to DONE with LINE_VALID always high (non-pipelined):
  - FULL/Y_ONLY: 1 + 9×2 + 4 + 1 = 24 cycles.
  - X_ONLY/COPY: 1 + 4×2 + 1 = 10 cycles.
- Each cycle LINE_VALID is low adds one cycle.
- RST_ASYNC_REG_COUNTER rises on the edge leaving IDLE; registered, glitch-free.

## Configuration
- INTERP_PIPELINE_EN defined: H_LOAD and H_FILT merge into H_RUN.
  - Line n+1 loads in the same cycle that line n is filtered.
  - An internal row-pending flag qualifies WRITE_BUFFER/WRITE_REG_INT_OUT and WRITE_REG_COUNTER.
  - LINE_REQ drops after the last line is accepted.
  - FULL latency: 1 + 10 + 4 + 1 = 16 cycles; X_ONLY/COPY: 1 + 5 + 1 = 7 cycles.
- Undefined: the two-state, 2-cycles-per-line flow above.

## Structure
- interpolation_pkg holds:
  - State enum.
  - Mode enum.
  - Constants LINES_FULL=9, LINES_SHORT=4, COUNT_END_V=13.
- One sub-module: interp_mode_decode, combinational FRAC_MV_X/Y → mode, reused by the upstream fetcher for burst sizing.

## Test plan
- FULL: START with X=5, Y=3, LINE_VALID high → 9 WRITE_BUFFER pulses, 4 OUT_VALID pulses, DONE at cycle 24 after START.
- Y_ONLY: X=0, Y=8 → SEL_BUFFER_IN=1 during all 9 H_FILT cycles, SEL_DIMENSION=0 in V_FILT, DONE at 24.
- X_ONLY and COPY: Y=0 → exactly 4 LINE_REQ acceptances, no WRITE_BUFFER, 4 OUT_VALID, DONE at 10.
- Stall: FULL job with LINE_VALID low for 3 cycles before line 5 → no enables during the stall, DONE at 27.
- Reset and START: RST_ASYNC_N low during V_FILT → all outputs 0 immediately, no DONE. A second START while BUSY is ignored, with no second DONE.
- With INTERP_PIPELINE_EN: FULL job → DONE at 16, WRITE_BUFFER asserted on 9 consecutive cycles.
